// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding imem reads
// and loads the IF/ID register, squashing fetches made stale by a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCsrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pcF;
    logic [31:0] w_pcFNext;
    logic        r_kill;
    logic        w_killNext;
    logic [31:0] r_bufInstr;
    logic [31:0] w_bufInstrNext;
    logic        w_load;
    logic [31:0] w_loadInstr;
    logic [31:0] w_pcPlus4F;

    logic [31:0] r_instrD;
    logic [31:0] r_pcD;
    logic [31:0] r_pcPlus4D;
    logic        r_validD;

    assign w_pcPlus4F = r_pcF + 32'd4;
    assign imem_req   = rst_n && (r_state == REQ);
    assign imem_addr  = r_pcF;
    assign InstrD     = r_instrD;
    assign PCD        = r_pcD;
    assign PCPlus4D   = r_pcPlus4D;
    assign ValidD     = r_validD;

    always_comb begin
        w_stateNext    = r_state;
        w_pcFNext      = r_pcF;
        w_killNext     = r_kill;
        w_bufInstrNext = r_bufInstr;
        w_load         = 1'b0;
        w_loadInstr    = imem_rdata;
        unique case (r_state)
            REQ: begin
                // A redirect coinciding with acceptance leaves a response in flight that must be dropped.
                if (imem_ready) begin
                    w_stateNext = WAIT;
                    w_killNext  = PCsrcE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_stateNext = REQ;
                    w_killNext  = 1'b0;
                    if (!r_kill && !PCsrcE) begin
                        if (StallD) begin
                            w_stateNext    = HOLD;
                            w_bufInstrNext = imem_rdata;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end else if (PCsrcE) begin
                    w_killNext = 1'b1;
                end
            end
            HOLD: begin
                if (PCsrcE) begin
                    w_stateNext = REQ;
                end else if (!StallD) begin
                    w_stateNext = REQ;
                    w_load      = 1'b1;
                    w_loadInstr = r_bufInstr;
                end
            end
            default: w_stateNext = REQ;
        endcase
        if (PCsrcE) begin
            w_pcFNext = PCTargetE;
        end else if (w_load) begin
            w_pcFNext = w_pcPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= REQ;
            r_pcF      <= RESET_PC;
            r_kill     <= 1'b0;
            r_bufInstr <= NOP_INSTR;
        end else begin
            r_state    <= w_stateNext;
            r_pcF      <= w_pcFNext;
            r_kill     <= w_killNext;
            r_bufInstr <= w_bufInstrNext;
        end
    end

    // IF/ID register: flush beats stall, stall beats a load, otherwise a bubble goes in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= 32'd0;
            r_pcPlus4D <= 32'd0;
            r_validD   <= 1'b0;
        end else if (FlushD) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= 32'd0;
            r_pcPlus4D <= 32'd0;
            r_validD   <= 1'b0;
        end else if (!StallD) begin
            if (w_load) begin
                r_instrD   <= w_loadInstr;
                r_pcD      <= r_pcF;
                r_pcPlus4D <= w_pcPlus4F;
                r_validD   <= 1'b1;
            end else begin
                r_instrD <= NOP_INSTR;
                r_validD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level fetch model checked every cycle, a
// single-outstanding memory responder, directed scenarios, then random traffic.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCsrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .PCsrcE(PCsrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h8) return 32'h00A0_0113;
        return {a[15:0], 16'h0513} ^ 32'h1357_0000;
    endfunction

    // Reference model: tracks whether a read is outstanding, whether it is stale,
    // and whether a returned word is parked waiting for the decode stall to lift.
    logic        mReady = 1'b0;
    logic [31:0] mPc, mBuf, mInstr, mPcD, mPc4D;
    logic        mBusy, mStale, mHeld, mValid;

    always @(posedge clk) begin : refModel
        logic        deliver;
        logic [31:0] dData;
        deliver = 1'b0;
        dData   = 32'd0;
        if (!rst_n) begin
            mPc = 32'd0; mBuf = NOP; mBusy = 1'b0; mStale = 1'b0; mHeld = 1'b0;
            mInstr = NOP; mPcD = 32'd0; mPc4D = 32'd0; mValid = 1'b0;
            mReady = 1'b1;
        end else if (mReady) begin
            if (mHeld) begin
                if (PCsrcE) mHeld = 1'b0;
                else if (!StallD) begin mHeld = 1'b0; deliver = 1'b1; dData = mBuf; end
            end else if (mBusy) begin
                if (imem_rvalid) begin
                    mBusy = 1'b0;
                    if (mStale || PCsrcE) mStale = 1'b0;
                    else if (StallD) begin mHeld = 1'b1; mBuf = imem_rdata; end
                    else begin deliver = 1'b1; dData = imem_rdata; end
                end else if (PCsrcE) begin
                    mStale = 1'b1;
                end
            end else if (imem_ready) begin
                mBusy  = 1'b1;
                mStale = PCsrcE;
            end
            if (FlushD) begin
                mInstr = NOP; mPcD = 32'd0; mPc4D = 32'd0; mValid = 1'b0;
            end else if (!StallD) begin
                if (deliver) begin mInstr = dData; mPcD = mPc; mPc4D = mPc + 32'd4; mValid = 1'b1; end
                else begin mInstr = NOP; mValid = 1'b0; end
            end
            if (PCsrcE) mPc = PCTargetE;
            else if (deliver) mPc = mPc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (mReady) begin
            checkOutput("imem_req", imem_req, rst_n && !mBusy && !mHeld);
            checkOutput("imem_addr", imem_addr, mPc);
            checkOutput("InstrD", InstrD, mInstr);
            checkOutput("PCD", PCD, mPcD);
            checkOutput("PCPlus4D", PCPlus4D, mPc4D);
            checkOutput("ValidD", ValidD, mValid);
        end
    end

    int          readyPct = 100;
    int          latency = 1;
    logic        overrideEn = 1'b0;
    logic [31:0] overrideData = 32'd0;
    logic        pending = 1'b0;
    int          waitCnt = 0;
    logic [31:0] pendAddr = 32'd0;
    logic [31:0] lastAccAddr = 32'd0;

    // One clock of the memory responder; returns 2 time units after the rising edge.
    task automatic applyStimulus();
        logic        acc;
        logic [31:0] accAddr;
        @(negedge clk);
        acc     = imem_req && imem_ready;
        accAddr = imem_addr;
        @(posedge clk);
        #2;
        if (acc) begin
            pending     = 1'b1;
            waitCnt     = latency - 1;
            pendAddr    = accAddr;
            lastAccAddr = accAddr;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pending) begin
            if (waitCnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = overrideEn ? overrideData : memWord(pendAddr);
                pending     = 1'b0;
            end else begin
                waitCnt--;
            end
        end
        imem_ready = ($urandom_range(99) < readyPct);
    endtask

    initial begin
        rst_n = 1'b0; PCsrcE = 1'b0; PCTargetE = 32'd0; StallD = 1'b0; FlushD = 1'b0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        #1;
        checkOutput("t1 first addr", imem_addr, 32'h0);
        checkOutput("t1 first req", imem_req, 1);
        checkOutput("t1 reset ValidD", ValidD, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("t1 InstrD", InstrD, 32'h0050_0093);
        checkOutput("t1 PCD", PCD, 32'h0);
        checkOutput("t1 PCPlus4D", PCPlus4D, 32'h4);
        checkOutput("t1 ValidD", ValidD, 1);
        checkOutput("t1 next addr", imem_addr, 32'h4);

        readyPct = 0; imem_ready = 1'b0;
        repeat (3) begin
            applyStimulus();
            checkOutput("t2 addr held", imem_addr, 32'h4);
            checkOutput("t2 bubble", ValidD, 0);
        end
        readyPct = 100; imem_ready = 1'b1; latency = 2;
        applyStimulus();
        checkOutput("t2 wait no req", imem_req, 0);
        applyStimulus();
        checkOutput("t2 still bubble", ValidD, 0);
        applyStimulus();
        checkOutput("t2 PCD", PCD, 32'h4);
        checkOutput("t2 InstrD", InstrD, memWord(32'h4));
        checkOutput("t2 ValidD", ValidD, 1);

        latency = 1;
        applyStimulus();
        StallD = 1'b1;
        applyStimulus();
        checkOutput("t3 hold no req", imem_req, 0);
        applyStimulus();
        checkOutput("t3 hold no req 2", imem_req, 0);
        checkOutput("t3 IF/ID held", InstrD, NOP);
        checkOutput("t3 PCD held", PCD, 32'h4);
        StallD = 1'b0;
        applyStimulus();
        checkOutput("t3 InstrD", InstrD, 32'h00A0_0113);
        checkOutput("t3 PCD", PCD, 32'h8);
        checkOutput("t3 next req", imem_req, 1);
        checkOutput("t3 next addr", imem_addr, 32'hC);

        latency = 3;
        applyStimulus();
        PCsrcE = 1'b1; PCTargetE = 32'h100;
        applyStimulus();
        PCsrcE = 1'b0; FlushD = 1'b1; overrideEn = 1'b1; overrideData = 32'hDEAD_BEEF;
        applyStimulus();
        checkOutput("t4 flush InstrD", InstrD, NOP);
        checkOutput("t4 flush PCD", PCD, 32'h0);
        checkOutput("t4 flush ValidD", ValidD, 0);
        FlushD = 1'b0;
        applyStimulus();
        overrideEn = 1'b0;
        checkOutput("t4 killed InstrD", InstrD, NOP);
        checkOutput("t4 killed ValidD", ValidD, 0);
        checkOutput("t4 target addr", imem_addr, 32'h100);

        latency = 1; PCsrcE = 1'b1; PCTargetE = 32'h200;
        applyStimulus();
        checkOutput("t5a accepted old", lastAccAddr, 32'h100);
        PCsrcE = 1'b0;
        applyStimulus();
        checkOutput("t5a addr", imem_addr, 32'h200);
        checkOutput("t5a dropped", ValidD, 0);
        applyStimulus();
        checkOutput("t5a accepted target", lastAccAddr, 32'h200);
        applyStimulus();
        checkOutput("t5a PCD", PCD, 32'h200);
        checkOutput("t5a ValidD", ValidD, 1);

        applyStimulus();
        PCsrcE = 1'b1; PCTargetE = 32'h300;
        applyStimulus();
        PCsrcE = 1'b0;
        checkOutput("t5b addr", imem_addr, 32'h300);
        checkOutput("t5b dropped", ValidD, 0);
        latency = 2;
        applyStimulus();
        checkOutput("t5b accepted target", lastAccAddr, 32'h300);

        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        #1;
        checkOutput("t6 addr", imem_addr, 32'h0);
        checkOutput("t6 req", imem_req, 1);
        checkOutput("t6 InstrD", InstrD, NOP);
        checkOutput("t6 PCD", PCD, 32'h0);
        latency = 1;
        applyStimulus();
        checkOutput("t6 accepted", lastAccAddr, 32'h0);
        applyStimulus();
        checkOutput("t6 InstrD after", InstrD, 32'h0050_0093);
        checkOutput("t6 PCD after", PCD, 32'h0);

        PCsrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        applyStimulus();
        PCsrcE = 1'b0;
        applyStimulus();
        checkOutput("wrap addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus();
        applyStimulus();
        checkOutput("wrap PCD", PCD, 32'hFFFF_FFFC);
        checkOutput("wrap PCPlus4D", PCPlus4D, 32'h0);
        checkOutput("wrap next addr", imem_addr, 32'h0);

        readyPct = 60;
        for (int i = 0; i < 3000; i++) begin
            latency = $urandom_range(3, 1);
            applyStimulus();
            StallD    = ($urandom_range(99) < 25);
            FlushD    = ($urandom_range(99) < 8);
            PCsrcE    = ($urandom_range(99) < 8);
            PCTargetE = $urandom & 32'hFFFF_FFFC;
            rst_n     = ($urandom_range(199) != 0);
        end
        rst_n = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCsrcE = 1'b0;
        repeat (2) applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
